// File: rtl/i2c_seg_target.sv
// Write-only I2C target driving a 7-segment display.
// Decodes START/STOP, matches address, auto-increments pointer, drives seg_out.
module i2c_seg_target #(
  parameter logic [6:0]  DEV_ADDR  = 7'h2A,
  parameter int unsigned BLINK_DIV = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] seg_out,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_REG,
    S_REG_ACK, S_DATA, S_DATA_ACK, S_IGNORE
  } state_e;

  state_e       state_q;
  logic [2:0]   scl_q, sda_q;
  logic [2:0]   cnt_q;
  logic [6:0]   sh_q;
  logic [7:0]   ptr_q;
  logic         ack_q, ph_q;
  logic [7:0]   raw_q;
  logic [3:0]   hex_q;
  logic [2:0]   ctrl_q;
  logic [BLINK_DIV-1:0] blk_q;
  logic         phase_q;
  logic [7:0]   seg_d;
  logic [6:0]   hex7;

  logic scl_rise, scl_fall, start_c, stop_c;
  logic [7:0] byte_w;

  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start_c  = scl_q[1] & ~sda_q[1] & sda_q[2];
  assign stop_c   = scl_q[1] & sda_q[1] & ~sda_q[2];
  assign byte_w   = {sh_q, sda_q[1]};

  // Two-stage synchronizers plus a history stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_in};
      sda_q <= {sda_q[1:0], sda_in};
    end
  end

  // Protocol FSM, pointer and display registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      sh_q    <= 7'd0;
      ptr_q   <= 8'd0;
      ack_q   <= 1'b0;
      ph_q    <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      raw_q   <= 8'd0;
      hex_q   <= 4'd0;
      ctrl_q  <= 3'd0;
    end else if (start_c) begin
      state_q <= S_ADDR;
      cnt_q   <= 3'd0;
      busy    <= 1'b1;
      sda_oe  <= 1'b0;
    end else if (stop_c) begin
      state_q <= S_IDLE;
      busy    <= 1'b0;
      sda_oe  <= 1'b0;
    end else begin
      unique case (state_q)
        S_ADDR: if (scl_rise) begin
          sh_q  <= byte_w[6:0];
          cnt_q <= cnt_q + 3'd1;
          ph_q  <= 1'b0;
          ack_q <= 1'b1;
          if (cnt_q == 3'd7) begin
            if (byte_w[7:1] == DEV_ADDR && !byte_w[0])
              state_q <= S_ADDR_ACK;
            else
              state_q <= S_IGNORE;
          end
        end
        S_REG: if (scl_rise) begin
          sh_q  <= byte_w[6:0];
          cnt_q <= cnt_q + 3'd1;
          ph_q  <= 1'b0;
          ack_q <= 1'b1;
          if (cnt_q == 3'd7) begin
            ptr_q   <= byte_w;
            state_q <= S_REG_ACK;
          end
        end
        S_DATA: if (scl_rise) begin
          sh_q  <= byte_w[6:0];
          cnt_q <= cnt_q + 3'd1;
          ph_q  <= 1'b0;
          if (cnt_q == 3'd7) begin
            state_q <= S_DATA_ACK;
            ptr_q   <= ptr_q + 8'd1;
            ack_q   <= (ptr_q <= 8'd2);
            if (ptr_q <= 8'd2) begin
              unique case (1'b1)
                ptr_q == 8'd0: raw_q  <= byte_w;
                ptr_q == 8'd1: hex_q  <= byte_w[3:0];
                default:       ctrl_q <= byte_w[2:0];
              endcase
            end
          end
        end
        S_ADDR_ACK, S_REG_ACK, S_DATA_ACK: if (scl_fall) begin
          if (!ph_q) begin
            sda_oe <= ack_q;
            ph_q   <= 1'b1;
          end else begin
            sda_oe  <= 1'b0;
            cnt_q   <= 3'd0;
            state_q <= (state_q == S_ADDR_ACK) ? S_REG : S_DATA;
          end
        end
        default: sda_oe <= 1'b0;
      endcase
    end
  end

  // Hex digit to segment pattern {g..a}.
  always_comb begin
    hex7 = 7'h00;
    case (hex_q)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  end

  // Select raw or decoded pattern, blanked in the off blink phase.
  always_comb begin
    seg_d = ctrl_q[0] ? {ctrl_q[2], hex7} : raw_q;
    if (ctrl_q[1] && !phase_q) seg_d = 8'h00;
  end

  // Blink prescaler restarts visible whenever blink is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q   <= '0;
      phase_q <= 1'b1;
      seg_out <= 8'h00;
    end else begin
      seg_out <= seg_d;
      if (!ctrl_q[1]) begin
        blk_q   <= '0;
        phase_q <= 1'b1;
      end else begin
        blk_q <= blk_q + {{(BLINK_DIV-1){1'b0}}, 1'b1};
        if (&blk_q) phase_q <= ~phase_q;
      end
    end
  end

endmodule

// File: tb/tb_i2c_seg_target.sv
// Directed bench for i2c_seg_target.
// Bit-bangs an I2C controller on a wired-AND SDA line.
module tb_i2c_seg_target;
  localparam int N = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_drv = 1'b1;
  logic       sda_in;
  logic       sda_oe;
  logic       busy;
  logic [7:0] seg_out;
  logic       oe_seen = 1'b0;
  int         n_chk = 0;
  int         n_fail = 0;

  assign sda_in = sda_drv & ~sda_oe;

  always #5 clk = ~clk;

  always @(posedge clk) if (sda_oe) oe_seen <= 1'b1;

  i2c_seg_target #(.DEV_ADDR(7'h2A), .BLINK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda_in),
    .sda_oe(sda_oe), .seg_out(seg_out), .busy(busy)
  );

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bit_tx(input logic b);
    sda_drv = b; clks(N);
    scl = 1'b1; clks(N);
    scl = 1'b0; clks(N);
  endtask

  task automatic ack_rx(output logic a);
    sda_drv = 1'b1; clks(N);
    scl = 1'b1; clks(2);
    a = sda_oe; clks(N - 2);
    scl = 1'b0; clks(N);
  endtask

  task automatic byte_tx(input logic [7:0] b, input logic exp_ack,
                         input string tag);
    logic a;
    for (int i = 7; i >= 0; i--) bit_tx(b[i]);
    ack_rx(a);
    check(tag, {7'd0, a}, {7'd0, exp_ack});
  endtask

  task automatic start_c();
    sda_drv = 1'b1; clks(N);
    scl = 1'b1; clks(N);
    sda_drv = 1'b0; clks(N);
    scl = 1'b0; clks(N);
  endtask

  task automatic stop_c();
    sda_drv = 1'b0; clks(N);
    scl = 1'b1; clks(N);
    sda_drv = 1'b1; clks(N);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] v;
    logic a;
    int k;
    clks(2);
    check("rst_seg", seg_out, 8'h00);
    check("rst_oe", {7'd0, sda_oe}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    rst_n = 1'b1;
    clks(3);

    // Write 0xA5 to RAW with exact commit latency.
    start_c();
    check("t1_busy_hi", {7'd0, busy}, 8'd1);
    byte_tx(8'h54, 1'b1, "t1_addr_ack");
    byte_tx(8'h00, 1'b1, "t1_reg_ack");
    d = 8'hA5;
    for (int i = 7; i >= 1; i--) bit_tx(d[i]);
    sda_drv = d[0]; clks(N);
    scl = 1'b1; clks(3);
    check("t1_seg_before", seg_out, 8'h00);
    clks(1);
    check("t1_seg_after", seg_out, 8'hA5);
    clks(N - 4);
    scl = 1'b0; clks(N);
    ack_rx(a);
    check("t1_data_ack", {7'd0, a}, 8'd1);
    stop_c();
    check("t1_busy_lo", {7'd0, busy}, 8'd0);

    // Wrong address: no ACK anywhere, RAW untouched.
    oe_seen = 1'b0;
    start_c();
    byte_tx(8'h56, 1'b0, "t3_addr_nack");
    byte_tx(8'h00, 1'b0, "t3_reg_nack");
    byte_tx(8'hFF, 1'b0, "t3_data_nack");
    stop_c();
    check("t3_oe_never", {7'd0, oe_seen}, 8'd0);
    check("t3_seg_keep", seg_out, 8'hA5);

    // Read request NACKed, then a valid write.
    start_c();
    byte_tx(8'h55, 1'b0, "t4_read_nack");
    byte_tx(8'h00, 1'b0, "t4_ignored");
    stop_c();
    check("t4_busy_lo", {7'd0, busy}, 8'd0);
    start_c();
    byte_tx(8'h54, 1'b1, "t4_addr_ack");
    byte_tx(8'h00, 1'b1, "t4_reg_ack");
    byte_tx(8'h3C, 1'b1, "t4_data_ack");
    stop_c();
    check("t4_seg", seg_out, 8'h3C);

    // HEX=0xB then CTRL mode=1 dp=1 via auto-increment.
    start_c();
    byte_tx(8'h54, 1'b1, "t2_addr_ack");
    byte_tx(8'h01, 1'b1, "t2_reg_ack");
    byte_tx(8'h0B, 1'b1, "t2_hex_ack");
    byte_tx(8'h05, 1'b1, "t2_ctrl_ack");
    stop_c();
    check("t2_seg_hex", seg_out, 8'hFC);

    // Blink on raw 0x3C; pointer 3 byte NACKed.
    start_c();
    byte_tx(8'h54, 1'b1, "t5_addr_ack");
    byte_tx(8'h02, 1'b1, "t5_reg_ack");
    byte_tx(8'h02, 1'b1, "t5_ctrl_ack");
    byte_tx(8'h33, 1'b0, "t5_ptr3_nack");
    stop_c();
    v = seg_out;
    k = 0;
    while (seg_out === v && k < 40) begin
      clks(1);
      k++;
    end
    check("t5_toggle_seen", {7'd0, k < 40}, 8'd1);
    v = seg_out;
    clks(15);
    check("t5_hold", seg_out, v);
    clks(1);
    check("t5_toggle", seg_out, v ^ 8'h3C);
    clks(16);
    check("t5_toggle2", seg_out, v);
    start_c();
    byte_tx(8'h54, 1'b1, "t5b_addr_ack");
    byte_tx(8'h02, 1'b1, "t5b_reg_ack");
    byte_tx(8'h00, 1'b1, "t5b_ctrl_ack");
    stop_c();
    check("t5b_seg_raw", seg_out, 8'h3C);

    // Reset in the middle of a data byte.
    start_c();
    byte_tx(8'h54, 1'b1, "t6_addr_ack");
    byte_tx(8'h00, 1'b1, "t6_reg_ack");
    bit_tx(1'b1);
    bit_tx(1'b0);
    bit_tx(1'b1);
    check("t6_busy_pre", {7'd0, busy}, 8'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_seg", seg_out, 8'h00);
    check("t6_rst_oe", {7'd0, sda_oe}, 8'd0);
    check("t6_rst_busy", {7'd0, busy}, 8'd0);
    sda_drv = 1'b1;
    scl = 1'b1;
    clks(N);
    rst_n = 1'b1;
    clks(N);

    // Repeated START mid-byte discards it.
    start_c();
    byte_tx(8'h54, 1'b1, "t7_addr_ack");
    byte_tx(8'h00, 1'b1, "t7_reg_ack");
    bit_tx(1'b1);
    bit_tx(1'b0);
    bit_tx(1'b0);
    bit_tx(1'b0);
    start_c();
    check("t7_discard", seg_out, 8'h00);
    check("t7_busy", {7'd0, busy}, 8'd1);
    byte_tx(8'h54, 1'b1, "t7_rs_addr_ack");
    byte_tx(8'h00, 1'b1, "t7_rs_reg_ack");
    byte_tx(8'h81, 1'b1, "t7_rs_data_ack");
    stop_c();
    check("t7_seg", seg_out, 8'h81);
    check("t7_busy_lo", {7'd0, busy}, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_seg_target.md
Name: i2c_seg_target

Overview:
- Write-only I2C target (slave) that receives register writes from an external controller and drives the on-board 7-segment display.
- Sits between the chip pins and the segment outputs in the segment-controller top. It decodes START/STOP, matches the device address, auto-increments a register pointer and holds the display configuration.
- Generates the displayed segment pattern: raw bits or hex-decoded, with optional blink.

Parameters:
- DEV_ADDR, 7'h2A, 7-bit I2C device address the block ACKs.
- BLINK_DIV, 24, width of the blink prescaler. Blink phase toggles when the counter wraps, every 2^BLINK_DIV clk cycles.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- scl_in  in  1  raw SCL pin, asynchronous.
- sda_in  in  1  raw SDA pin, asynchronous.
- sda_oe  out  1  1 = pull SDA low (open-drain). Never drives high.
- seg_out  out  8  segments {dp,g,f,e,d,c,b,a}, active high.
- busy  out  1  high from a detected START until the next STOP.

Behaviour:
- Reset: all FSM, pointer and registers cleared. sda_oe=0, seg_out=0, busy=0, blink counter=0, blink phase=on.
- Input conditioning:
  - scl_in and sda_in each pass through a 2-FF synchronizer, then a 3rd FF for edge detect.
  - All protocol decisions use the synchronized values. clk must be >= 8x SCL.
- Conditions (evaluated in every FSM state, including mid-byte and mid-ACK):
  - START = SDA falling while SCL high. Enter ADDR, clear bit count, busy=1. A repeated START behaves identically.
  - STOP = SDA rising while SCL high. Enter IDLE, sda_oe=0, busy=0.
  - A START or STOP seen mid-byte aborts that byte without writing.
- Sampling: SDA is sampled on SCL rising, MSB first. sda_oe changes only on SCL falling.
- FSM states:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. If bits[7:1]==DEV_ADDR and bit0==0 (write), go to ADDR_ACK; otherwise go to IGNORE (no ACK). Read requests are always NACKed.
  - ADDR_ACK: assert sda_oe on the SCL falling edge after the 8th bit. Release it on the next SCL falling edge, then go to REG.
  - REG: shift 8 bits into the pointer, then REG_ACK (always ACKed, same timing as ADDR_ACK), then DATA.
  - DATA: shift 8 bits. If pointer <= 2, write the register and ACK; else NACK with no write. Either way go to DATA_ACK.
  - DATA_ACK: the pointer increments by 1 after every data byte (8-bit, 0xFF wraps to 0x00). Then back to DATA.
  - IGNORE: sda_oe=0 until START or STOP.
- Write timing: a register write commits on the clk cycle after the synchronized 8th SCL rising edge of a DATA byte. seg_out reflects it one further cycle later (registered output).
- Registers:
  - 0x00 RAW[7:0].
  - 0x01 HEX[3:0]; upper bits are written but ignored.
  - 0x02 CTRL: bit0 mode (0 raw, 1 hex), bit1 blink_en, bit2 dp. Bits 7:3 are read-as-ignored.
- Hex decode table (g..a), values 0-F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
- Output:
  - mode=0: seg_next = RAW.
  - mode=1: seg_next = {dp, decode(HEX)}.
  - If blink_en=1 and blink phase=off, seg_next = 8'h00.
  - seg_out is registered.
- Blink counter: free-running while blink_en=1. Held at 0 with phase=on while blink_en=0, so enabling blink always starts in the visible phase.
- Simultaneous events: a START/STOP detected in the same cycle as an SCL edge takes priority. A STOP while sda_oe=1 releases sda_oe that cycle.

Test Plan:
- START, 0x54 (addr 2A W), 0x00, 0xA5, STOP -> ACK on all three bytes; seg_out=8'hA5 two clk after the 8th data rise; busy low after STOP.
- START, 0x54, 0x01, 0x0B, 0x05 (auto-increment to CTRL: mode=1, dp=1), STOP -> seg_out=8'hFC.
- START, 0x56 (wrong addr), 0x00, 0xFF, STOP -> no ACK on any byte, sda_oe stays 0, RAW unchanged.
- START, 0x55 (read) -> NACK, IGNORE until STOP; a following valid write still works.
- START, 0x54, 0x02, 0x02, 0x33, STOP with BLINK_DIV=4 -> blink_en=1; seg_out toggles between pattern and 00 every 16 clk; pointer 3 byte NACKed, no write.
- Assert rst_n=0 in mid-DATA byte -> all outputs 0 immediately. Repeated START mid-byte -> byte discarded, new address phase ACKed.
